// File: rtl/event_queue_if.sv
// Event queue port bundle: writer/reader request side and queue status side.
interface event_queue_if #(
  parameter int EVENT_WIDTH = 8,
  parameter int CNT_WIDTH   = 4
);
  logic [EVENT_WIDTH-1:0] FifoInput;
  logic                   FifoWr;
  logic                   FifoRd;
  logic [EVENT_WIDTH-1:0] FifoOutput;
  logic                   empty;
  logic                   full;
  logic                   almost_full;
  logic [CNT_WIDTH-1:0]   count;
  logic                   overflow;
  logic                   underflow;

  // Scanner/host side: drives requests and data, observes status.
  modport master (
    output FifoInput, FifoWr, FifoRd,
    input  FifoOutput, empty, full, almost_full, count, overflow, underflow
  );

  // Queue side.
  modport slave (
    input  FifoInput, FifoWr, FifoRd,
    output FifoOutput, empty, full, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/event_queue.sv
// Keyboard-event queue: level requests are edge-detected into one-shot
// strobes that act one edge later; circular buffer with any DEPTH >= 2,
// selectable drop/overwrite policy on full, sticky error flags, sync clear.
module event_queue #(
  parameter int EVENT_WIDTH = 8,
  parameter int DEPTH       = 8,
  parameter int PTR_WIDTH   = 3,
  parameter int CNT_WIDTH   = 4,
  parameter int AF_LEVEL    = 6,
  parameter int OVF_MODE    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  event_queue_if.slave  bus
);

  logic                   wr_q, rd_q, wr_strb, rd_strb;
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [EVENT_WIDTH-1:0] mem [DEPTH];
  logic [EVENT_WIDTH-1:0] dout;
  logic                   ovf, udf;
  logic                   is_empty, is_full;
  logic                   do_rd, rd_empty, do_wr, wr_full, overwrite;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_WIDTH-1:0] nxt(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_WIDTH'(DEPTH));

  // Decode this edge's action; a read alongside a full write frees the slot.
  always_comb begin
    do_rd     = rd_strb & ~is_empty;
    rd_empty  = rd_strb &  is_empty;
    wr_full   = wr_strb &  is_full & ~rd_strb;
    overwrite = wr_full & (OVF_MODE != 0);
    do_wr     = wr_strb & (~wr_full | overwrite);
  end

  // Request edge detectors; keep tracking through clr so held lines don't re-fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_strb <= 1'b0;
      rd_strb <= 1'b0;
    end else begin
      wr_strb <= bus.FifoWr & ~wr_q;
      rd_strb <= bus.FifoRd & ~rd_q;
      wr_q    <= bus.FifoWr;
      rd_q    <= bus.FifoRd;
    end
  end

  // Pointers, level, output register and sticky flags; rst/clr override strobes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_rd) begin
        dout <= mem[rd_ptr];
      end else if (rd_empty) begin
        dout <= '0;
        udf  <= 1'b1;
      end
      if (do_rd || overwrite) rd_ptr <= nxt(rd_ptr);
      if (do_wr)              wr_ptr <= nxt(wr_ptr);
      if (wr_full)            ovf    <= 1'b1;
      if (do_wr && !do_rd && !overwrite) cnt <= cnt + CNT_WIDTH'(1);
      else if (do_rd && !do_wr)          cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && !clr && do_wr) mem[wr_ptr] <= bus.FifoInput;
  end

  assign bus.FifoOutput  = dout;
  assign bus.count       = cnt;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= CNT_WIDTH'(AF_LEVEL));
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;

endmodule

// File: tb/tb_event_queue.sv
// Bench for event_queue: three instances (DEPTH 8 drop, DEPTH 8 overwrite,
// DEPTH 5 drop with AF 4) share one stimulus stream; each is compared every
// cycle against a list-based reference model, plus directed spot checks.
module tb_event_queue;

  logic clk = 1'b0;
  logic rst, clr, wr, rd;
  logic [7:0] din;

  always #5 clk = ~clk;

  event_queue_if #(.EVENT_WIDTH(8), .CNT_WIDTH(4)) if0 ();
  event_queue_if #(.EVENT_WIDTH(8), .CNT_WIDTH(4)) if1 ();
  event_queue_if #(.EVENT_WIDTH(8), .CNT_WIDTH(3)) if2 ();

  assign if0.FifoInput = din; assign if0.FifoWr = wr; assign if0.FifoRd = rd;
  assign if1.FifoInput = din; assign if1.FifoWr = wr; assign if1.FifoRd = rd;
  assign if2.FifoInput = din; assign if2.FifoWr = wr; assign if2.FifoRd = rd;

  event_queue #(.EVENT_WIDTH(8), .DEPTH(8), .PTR_WIDTH(3), .CNT_WIDTH(4),
                .AF_LEVEL(6), .OVF_MODE(0)) dut0 (.clk(clk), .rst(rst), .clr(clr), .bus(if0));
  event_queue #(.EVENT_WIDTH(8), .DEPTH(8), .PTR_WIDTH(3), .CNT_WIDTH(4),
                .AF_LEVEL(6), .OVF_MODE(1)) dut1 (.clk(clk), .rst(rst), .clr(clr), .bus(if1));
  event_queue #(.EVENT_WIDTH(8), .DEPTH(5), .PTR_WIDTH(3), .CNT_WIDTH(3),
                .AF_LEVEL(4), .OVF_MODE(0)) dut2 (.clk(clk), .rst(rst), .clr(clr), .bus(if2));

  localparam int MDEP [3] = '{8, 8, 5};
  localparam int MAF  [3] = '{6, 6, 4};
  localparam int MMODE[3] = '{0, 1, 0};

  int tests = 0;
  int fails = 0;

  // Reference model: oldest event at index 0.
  logic [7:0] mlist [3][16];
  int         mlen  [3];
  logic [7:0] mout  [3];
  bit         movf  [3];
  bit         mudf  [3];
  bit         pw, pr, qw, qr;   // pending strobes / previous request levels

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int k);
    mlen[k] = 0; mout[k] = 8'h00; movf[k] = 1'b0; mudf[k] = 1'b0;
  endtask

  task automatic model_pop(input int k);
    for (int i = 0; i < 15; i++) mlist[k][i] = mlist[k][i+1];
    mlen[k]--;
  endtask

  task automatic model_act(input int k, input bit w, input bit r, input logic [7:0] d);
    if (r) begin
      if (mlen[k] > 0) begin
        mout[k] = mlist[k][0];
        model_pop(k);
      end else begin
        mout[k] = 8'h00;
        mudf[k] = 1'b1;
      end
    end
    if (w) begin
      if (mlen[k] < MDEP[k]) begin
        mlist[k][mlen[k]] = d; mlen[k]++;
      end else begin
        movf[k] = 1'b1;
        if (MMODE[k] != 0) begin
          model_pop(k);
          mlist[k][mlen[k]] = d; mlen[k]++;
        end
      end
    end
  endtask

  task automatic chk_dut(input int k, input logic [7:0] o, input int c, input bit e,
                         input bit f, input bit af, input bit ov, input bit ud);
    string p;
    p = $sformatf("d%0d_", k);
    chk({p, "out"},   int'(o),  int'(mout[k]));
    chk({p, "count"}, c,        mlen[k]);
    chk({p, "empty"}, int'(e),  int'(mlen[k] == 0));
    chk({p, "full"},  int'(f),  int'(mlen[k] == MDEP[k]));
    chk({p, "afull"}, int'(af), int'(mlen[k] >= MAF[k]));
    chk({p, "ovf"},   int'(ov), int'(movf[k]));
    chk({p, "udf"},   int'(ud), int'(mudf[k]));
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic tick(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr = w; rd = r; din = d; clr = c;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) model_clear(k);
      pw = 0; pr = 0; qw = 0; qr = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (c) model_clear(k);
        else   model_act(k, pw, pr, d);
      end
      pw = w & ~qw; pr = r & ~qr; qw = w; qr = r;
    end
    #1;
    chk_dut(0, if0.FifoOutput, int'(if0.count), if0.empty, if0.full, if0.almost_full, if0.overflow, if0.underflow);
    chk_dut(1, if1.FifoOutput, int'(if1.count), if1.empty, if1.full, if1.almost_full, if1.overflow, if1.underflow);
    chk_dut(2, if2.FifoOutput, int'(if2.count), if2.empty, if2.full, if2.almost_full, if2.overflow, if2.underflow);
  endtask

  task automatic push(input logic [7:0] d);
    tick(1, 0, d, 0);
    tick(0, 0, d, 0);
  endtask

  task automatic pop;
    tick(0, 1, 8'h00, 0);
    tick(0, 0, 8'h00, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(0, 0, 8'h00, 0);
    tick(0, 0, 8'h00, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    pw = 0; pr = 0; qw = 0; qr = 0;

    // Reset state.
    do_reset;
    chk("rst_out",   int'(if0.FifoOutput), 0);
    chk("rst_empty", int'(if0.empty), 1);
    chk("rst_count", int'(if0.count), 0);
    chk("rst_flags", int'({if0.full, if0.almost_full, if0.overflow, if0.underflow}), 0);

    // Three writes then three reads, FIFO order.
    push(8'h11); push(8'h22); push(8'h33);
    chk("w3_count", int'(if0.count), 3);
    pop; chk("rd_11", int'(if0.FifoOutput), 8'h11);
    pop; chk("rd_22", int'(if0.FifoOutput), 8'h22);
    pop; chk("rd_33", int'(if0.FifoOutput), 8'h33);
    chk("rd3_empty", int'(if0.empty), 1);
    chk("rd3_flags", int'({if0.overflow, if0.underflow}), 0);

    // Held read request gives exactly one read.
    push(8'h44); push(8'h55);
    for (int i = 0; i < 10; i++) tick(0, 1, 8'h00, 0);
    tick(0, 0, 8'h00, 0);
    chk("hold_count", int'(if0.count), 1);
    chk("hold_out", int'(if0.FifoOutput), 8'h44);
    pop;

    // Nine writes: drop (dut0) versus overwrite-oldest (dut1).
    do_reset;
    for (int i = 1; i <= 9; i++) push(8'(i));
    chk("ovf_full", int'(if0.full), 1);
    chk("ovf_flag", int'(if0.overflow), 1);
    chk("ovw_flag", int'(if1.overflow), 1);
    chk("ovw_count", int'(if1.count), 8);
    for (int i = 1; i <= 8; i++) begin
      pop;
      chk($sformatf("drop_rd%0d", i), int'(if0.FifoOutput), i);
      chk($sformatf("ovw_rd%0d", i),  int'(if1.FifoOutput), i + 1);
    end

    // Read on empty, then simultaneous write+read from empty.
    do_reset;
    pop;
    chk("ud_out", int'(if0.FifoOutput), 0);
    chk("ud_flag", int'(if0.underflow), 1);
    chk("ud_count", int'(if0.count), 0);
    push(8'h77);
    pop;   // out now 0x77, then queue empty again
    tick(1, 1, 8'h00, 0);
    tick(0, 0, 8'hAB, 0);
    chk("sim_count", int'(if0.count), 1);
    chk("sim_out", int'(if0.FifoOutput), 0);

    // DEPTH 5: order across pointer wrap, then almost_full threshold.
    do_reset;
    for (int i = 0; i < 20; i++) begin
      push(8'(8'hA0 + i));
      pop;
      chk($sformatf("wrap_rd%0d", i), int'(if2.FifoOutput), 8'hA0 + i);
    end
    push(8'h01); push(8'h02); push(8'h03);
    chk("af_at3", int'(if2.almost_full), 0);
    push(8'h04);
    chk("af_at4", int'(if2.almost_full), 1);

    // Request high as reset releases counts as a rising edge.
    rst = 1'b1;
    tick(1, 0, 8'h00, 0);
    rst = 1'b0;
    tick(1, 0, 8'h00, 0);
    tick(0, 0, 8'h5A, 0);
    chk("rstrise_count", int'(if0.count), 1);

    // Clear with events queued and overflow set; held write must not re-fire.
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    chk("pre_clr_ovf", int'(if2.overflow), 1);
    tick(1, 0, 8'h00, 0);
    tick(1, 0, 8'h99, 1);
    tick(1, 0, 8'h99, 0);
    tick(0, 0, 8'h99, 0);
    chk("clr_count", int'(if0.count), 0);
    chk("clr_empty", int'(if0.empty), 1);
    chk("clr_ovf", int'(if2.overflow), 0);
    pop;
    chk("clr_rd_out", int'(if0.FifoOutput), 0);
    chk("clr_rd_udf", int'(if0.underflow), 1);

    // Randomized levels, data and occasional clear.
    for (int i = 0; i < 600; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 39) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
